// File: rtl/rc6_job_scheduler.sv
// Round-robin scheduler sharing one RC6 core among NREQ requesters: one job in
// flight, result returned with the requester ID, hung core reported as rsp_err.
module rc6_job_scheduler #(
  parameter int  NREQ    = 2,
  parameter int  TIMEOUT = 63,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*128-1:0]  req_data,
  input  logic [NREQ-1:0]      req_zset,
  output logic                 core_start,
  output logic                 core_zset,
  output logic [127:0]         core_din,
  input  logic                 core_done,
  input  logic [127:0]         core_dout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [127:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e          state_q;
  logic [ID_W-1:0] rr_q, grant_q, grant_d;
  logic            grant_vld_d;
  logic [7:0]      cnt_q;
  logic [127:0]    job_data_d;
  logic            job_zset_d;
  logic            core_start_q, core_zset_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [127:0]    core_din_q, rsp_data_q;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_d     = '0;
    job_data_d  = '0;
    job_zset_d  = 1'b0;
    req_ready   = '0;
    // First pass: lowest valid at or above the pointer; second pass wraps.
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld_d && req_valid[i] && (ID_W'(i) >= rr_q)) begin
        grant_vld_d = 1'b1;
        grant_d     = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld_d && req_valid[i]) begin
        grant_vld_d = 1'b1;
        grant_d     = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == grant_d) begin
        job_data_d   = req_data[128*i +: 128];
        job_zset_d   = req_zset[i];
        // Gated by reset so no accept is advertised while held in reset.
        req_ready[i] = grant_vld_d && (state_q == IDLE) && reset;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      core_zset_q  <= 1'b0;
      core_din_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            grant_q      <= grant_d;
            core_din_q   <= job_data_d;
            core_zset_q  <= job_zset_d;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (core_done) begin
            rsp_data_q  <= core_dout;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == TMO_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_q        <= (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_zset  = core_zset_q;
  assign core_din   = core_din_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = grant_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rc6_job_scheduler.sv
// Directed bench for rc6_job_scheduler: reset, single job, reset mid-job,
// round-robin, timeout, backpressure and spurious core_done.
module tb_rc6_job_scheduler;

  localparam logic [127:0] D0   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D1   = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
  localparam logic [127:0] X2   = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
  localparam logic [127:0] R0   = 128'h00000000_00000000_00000000_000000C0;
  localparam logic [127:0] R1   = 128'h10000000_00000000_00000000_000000C1;
  localparam logic [127:0] R2   = 128'h20000000_00000000_00000000_000000C2;
  localparam logic [127:0] R3   = 128'h30000000_00000000_00000000_000000C3;
  localparam logic [127:0] R4   = 128'hDEADBEEF_00000000_00000000_000000C4;
  localparam logic [127:0] R5   = 128'hCAFEF00D_00000000_00000000_000000C5;
  localparam logic [127:0] JUNK = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, req_zset;
  logic [255:0] req_data;
  logic         core_start, core_zset, core_done;
  logic [127:0] core_din, core_dout;
  logic         rsp_valid, rsp_ready, rsp_err, busy;
  logic [127:0] rsp_data;
  logic [0:0]   rsp_id;

  int total = 0;
  int bad   = 0;

  rc6_job_scheduler #(.NREQ(2), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_zset(req_zset),
    .core_start(core_start), .core_zset(core_zset), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge in IDLE with req_valid already driven.
  task automatic accept(input logic [1:0] exp_ready, input logic [127:0] exp_din,
                        input logic exp_zset);
    #1 check("req_ready", req_ready, exp_ready);
    @(negedge clk);
    check("issue_start", core_start, 1'b1);
    check("issue_din", core_din, exp_din);
    check("issue_zset", core_zset, exp_zset);
    check("issue_ready", req_ready, 2'b00);
    check("issue_busy", busy, 1'b1);
  endtask

  // Called at the ISSUE falling edge; pulses core_done after wait_cyc WAIT edges.
  task automatic finish_job(input int wait_cyc, input logic [127:0] dout,
                            input logic exp_id, input logic [127:0] exp_din,
                            input logic exp_zset);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check("wait_start", core_start, 1'b0);
      check("wait_din", core_din, exp_din);
      check("wait_zset", core_zset, exp_zset);
      check("wait_rsp", rsp_valid, 1'b0);
    end
    core_done = 1'b1;
    core_dout = dout;
    @(negedge clk);
    core_done = 1'b0;
    core_dout = '0;
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_data", rsp_data, dout);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_err", rsp_err, 1'b0);
    check("rsp_busy", busy, 1'b1);
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_rsp_busy", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 2'b11;
    req_data  = {D1, D0};
    req_zset  = 2'b01;
    core_done = 1'b0;
    core_dout = '0;
    rsp_ready = 1'b1;

    // Reset held with both requesters valid
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 2'b00);
    check("rst_start", core_start, 1'b0);
    check("rst_din", core_din, 128'h0);
    check("rst_zset", core_zset, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 128'h0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // First grant after release is requester 0; single encrypt job
    reset = 1'b1;
    accept(2'b01, D0, 1'b1);
    req_valid = 2'b00;
    finish_job(20, X2, 1'b0, D0, 1'b1);

    // Reset in the middle of WAIT abandons the job
    req_valid = 2'b10;
    accept(2'b10, D1, 1'b0);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_din", core_din, 128'h0);
    check("midrst_start", core_start, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 1'b0);
      check("midrst_idle", busy, 1'b0);
    end

    // Round robin with both requesters continuously valid
    req_valid = 2'b11;
    accept(2'b01, D0, 1'b1);
    finish_job(2, R0, 1'b0, D0, 1'b1);
    accept(2'b10, D1, 1'b0);
    finish_job(3, R1, 1'b1, D1, 1'b0);
    accept(2'b01, D0, 1'b1);
    finish_job(1, R2, 1'b0, D0, 1'b1);
    accept(2'b10, D1, 1'b0);
    finish_job(4, R3, 1'b1, D1, 1'b0);
    req_valid = 2'b00;

    // Timeout: no core_done, response exactly 63 cycles into WAIT
    req_valid = 2'b01;
    accept(2'b01, D0, 1'b1);
    req_valid = 2'b00;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      check("tmo_wait", rsp_valid, 1'b0);
    end
    @(negedge clk);
    check("tmo_valid", rsp_valid, 1'b1);
    check("tmo_err", rsp_err, 1'b1);
    check("tmo_data", rsp_data, 128'h0);
    check("tmo_id", rsp_id, 1'b0);
    @(negedge clk);
    check("tmo_done", rsp_valid, 1'b0);

    // core_done on the timeout cycle wins
    req_valid = 2'b10;
    accept(2'b10, D1, 1'b0);
    req_valid = 2'b00;
    finish_job(63, R4, 1'b1, D1, 1'b0);

    // Spurious core_done in IDLE
    core_done = 1'b1;
    core_dout = JUNK;
    @(negedge clk);
    core_done = 1'b0;
    core_dout = '0;
    check("spur_idle_busy", busy, 1'b0);
    check("spur_idle_rsp", rsp_valid, 1'b0);
    check("spur_idle_data", rsp_data, R4);

    // Backpressure with a spurious core_done during RESP
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    accept(2'b01, D0, 1'b1);
    req_valid = 2'b00;
    @(negedge clk);
    core_done = 1'b1;
    core_dout = R5;
    @(negedge clk);
    core_done = 1'b0;
    check("bp_valid", rsp_valid, 1'b1);
    check("bp_data", rsp_data, R5);
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      core_done = (i == 3);
      core_dout = (i == 3) ? JUNK : '0;
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_data", rsp_data, R5);
      check("bp_hold_id", rsp_id, 1'b0);
      check("bp_hold_err", rsp_err, 1'b0);
      check("bp_no_grant", req_ready, 2'b00);
      check("bp_no_start", core_start, 1'b0);
    end
    core_done = 1'b0;
    core_dout = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_released", rsp_valid, 1'b0);
    check("bp_next_grant", req_ready, 2'b10);
    req_valid = 2'b00;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
